// File: rtl/loadable_down_counter.sv
// Programmable down-counter/timer: loads a start value, decrements on each enabled
// clock, pulses done at terminal count and optionally reloads for periodic operation.
module loadable_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             x,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] z,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01
  } state_t;

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  state_t           state_r;
  state_t           state_s;
  logic [WIDTH-1:0] z_r;
  logic [WIDTH-1:0] z_s;
  logic [WIDTH-1:0] reload_r;
  logic [WIDTH-1:0] reload_s;
  logic             busy_r;
  logic             busy_s;
  logic             done_r;
  logic             done_s;

  // Next-state and next-output decode; load overrides everything else.
  always_comb begin
    state_s  = state_r;
    z_s      = z_r;
    reload_s = reload_r;
    done_s   = 1'b0;
    if (load) begin
      z_s      = din;
      reload_s = din;
      if (din != ZERO) begin
        state_s = RUN;
      end else begin
        state_s = IDLE;
      end
    end else begin
      case (state_r)
        IDLE: begin
          state_s = IDLE;
        end
        RUN: begin
          if (x) begin
            if (z_r == ZERO) begin
              // Unreachable in normal operation; bail out without a done pulse.
              state_s = IDLE;
            end else if (z_r == ONE) begin
              done_s = 1'b1;
              if (auto_reload) begin
                z_s     = reload_r;
                state_s = RUN;
              end else begin
                z_s     = ZERO;
                state_s = IDLE;
              end
            end else begin
              z_s = z_r - ONE;
            end
          end else begin
            state_s = RUN;
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
    if (state_s == RUN) begin
      busy_s = 1'b1;
    end else begin
      busy_s = 1'b0;
    end
  end

  // State and output registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= IDLE;
      z_r      <= ZERO;
      reload_r <= ZERO;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      z_r      <= z_s;
      reload_r <= reload_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
    end
  end

  assign z    = z_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: tb/tb_loadable_down_counter.sv
// Scoreboard bench for loadable_down_counter: directed stimulus pushes expected
// outputs per clock, an independent monitor pops and compares after each edge.
module tb_loadable_down_counter;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst;
  logic             load;
  logic [WIDTH-1:0] din;
  logic             x;
  logic             auto_reload;
  logic [WIDTH-1:0] z;
  logic             busy;
  logic             done;

  typedef struct {
    logic [WIDTH-1:0] z;
    logic             busy;
    logic             done;
    string            tag;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp;
  int   n_bad;

  loadable_down_counter #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .din         (din),
    .x           (x),
    .auto_reload (auto_reload),
    .z           (z),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] ez, input logic eb, input logic ed);
    n_cmp = n_cmp + 1;
    if (z !== ez || busy !== eb || done !== ed) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got z=%0d busy=%0b done=%0b, expected z=%0d busy=%0b done=%0b",
               tag, z, busy, done, ez, eb, ed);
    end
  endtask

  // Drive one clock of stimulus and record what the outputs must show after the edge.
  task automatic step(input string tag, input logic ld, input logic [WIDTH-1:0] d,
                      input logic en, input logic ar,
                      input logic [WIDTH-1:0] ez, input logic eb, input logic ed);
    exp_t e;
    @(negedge clk);
    load        = ld;
    din         = d;
    x           = en;
    auto_reload = ar;
    e.z    = ez;
    e.busy = eb;
    e.done = ed;
    e.tag  = tag;
    sb_q.push_back(e);
  endtask

  // Monitor: every posedge, compare outputs against the oldest pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check(e.tag, e.z, e.busy, e.done);
      end
    end
  end

  initial begin
    n_cmp       = 0;
    n_bad       = 0;
    rst         = 1'b1;
    load        = 1'b0;
    din         = '0;
    x           = 1'b0;
    auto_reload = 1'b0;
    #2 rst = 1'b0;
    #1 check("reset_init", 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // One-shot from 5
    step("os_load", 1'b1, 4'd5, 1'b1, 1'b0, 4'd5, 1'b1, 1'b0);
    step("os_4",    1'b0, 4'd0, 1'b1, 1'b0, 4'd4, 1'b1, 1'b0);
    step("os_3",    1'b0, 4'd0, 1'b1, 1'b0, 4'd3, 1'b1, 1'b0);
    step("os_2",    1'b0, 4'd0, 1'b1, 1'b0, 4'd2, 1'b1, 1'b0);
    step("os_1",    1'b0, 4'd0, 1'b1, 1'b0, 4'd1, 1'b1, 1'b0);
    step("os_term", 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
    step("os_stay", 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);

    // Enable gating
    step("eg_load", 1'b1, 4'd3, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0);
    step("eg_x1",   1'b0, 4'd0, 1'b1, 1'b0, 4'd2, 1'b1, 1'b0);
    step("eg_x0a",  1'b0, 4'd0, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0);
    step("eg_x0b",  1'b0, 4'd0, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0);
    step("eg_x1b",  1'b0, 4'd0, 1'b1, 1'b0, 4'd1, 1'b1, 1'b0);
    step("eg_term", 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1);

    // Auto-reload period 3
    step("ar_load", 1'b1, 4'd3, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0);
    for (int p = 0; p < 3; p++) begin
      step("ar_2",   1'b0, 4'd0, 1'b1, 1'b1, 4'd2, 1'b1, 1'b0);
      step("ar_1",   1'b0, 4'd0, 1'b1, 1'b1, 4'd1, 1'b1, 1'b0);
      step("ar_rel", 1'b0, 4'd0, 1'b1, 1'b1, 4'd3, 1'b1, 1'b1);
    end

    // Load coincident with terminal, then load zero
    step("lt_load",  1'b1, 4'd2, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0);
    step("lt_1",     1'b0, 4'd0, 1'b1, 1'b0, 4'd1, 1'b1, 1'b0);
    step("lt_win",   1'b1, 4'd9, 1'b1, 1'b0, 4'd9, 1'b1, 1'b0);
    step("lz_load",  1'b1, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    step("lz_idle",  1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);

    // Full range from 15, no wrap
    step("fr_load", 1'b1, 4'd15, 1'b1, 1'b0, 4'd15, 1'b1, 1'b0);
    for (int v = 14; v >= 1; v--) begin
      step("fr_cnt", 1'b0, 4'd0, 1'b1, 1'b0, 4'(v), 1'b1, 1'b0);
    end
    step("fr_term", 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
    step("fr_nowr", 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);

    // Reload value 1: back-to-back terminals, then drop auto_reload
    step("r1_load", 1'b1, 4'd1, 1'b0, 1'b1, 4'd1, 1'b1, 1'b0);
    step("r1_t1",   1'b0, 4'd0, 1'b1, 1'b1, 4'd1, 1'b1, 1'b1);
    step("r1_t2",   1'b0, 4'd0, 1'b1, 1'b1, 4'd1, 1'b1, 1'b1);
    step("r1_t3",   1'b0, 4'd0, 1'b1, 1'b1, 4'd1, 1'b1, 1'b1);
    step("r1_stop", 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
    step("r1_idle", 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);

    // Asynchronous reset mid-run at z=7
    step("rm_load", 1'b1, 4'd7, 1'b0, 1'b0, 4'd7, 1'b1, 1'b0);
    step("rm_hold", 1'b0, 4'd0, 1'b0, 1'b0, 4'd7, 1'b1, 1'b0);
    @(posedge clk);
    #3 x = 1'b1;
    rst = 1'b0;
    #1 check("rm_async", 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    step("rm_idle1", 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    step("rm_idle2", 1'b0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #2;
    n_cmp = n_cmp + 1;
    if (sb_q.size() != 0) begin
      n_bad = n_bad + 1;
      $display("FAIL drain: got %0d pending entries, expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
